// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: pin conditioning, 11-bit frame deframing with
// odd-parity/stop/timeout checks, and E0/F0 prefix folding into one key-event strobe.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | bus idle, waiting for a start bit (0) on a falling edge
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the parity bit
// S_STOP   | sampling the stop bit, checking the frame, back to idle
module ps2_scancode_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 16000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       extended,
    output logic       key_release,
    output logic       valid,
    output logic       err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
    localparam logic [7:0]    FL_LAST = 8'(FILTER_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Index 0 is the clock line, index 1 the data line.
    logic [1:0]    sync_1, sync_2, flt;
    logic [7:0]    flt_cnt [2];
    logic          fclk_d;
    logic          fall, fdat;

    state_t        state, state_nx;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          ext_pend, brk_pend;
    logic          byte_done, frame_err, tmo_hit;

    assign fall = fclk_d & ~flt[0];
    assign fdat = flt[1];

    // A line level only moves after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 2'b11;
            sync_2 <= 2'b11;
            flt    <= 2'b11;
            fclk_d <= 1'b1;
            for (int i = 0; i < 2; i++) flt_cnt[i] <= 8'd0;
        end else begin
            sync_1 <= {ps2_data, ps2_clk};
            sync_2 <= sync_1;
            fclk_d <= flt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync_2[i] == flt[i]) begin
                    flt_cnt[i] <= 8'd0;
                end else if (flt_cnt[i] == FL_LAST) begin
                    flt[i]     <= sync_2[i];
                    flt_cnt[i] <= 8'd0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        byte_done = 1'b0;
        frame_err = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            S_IDLE:   if (fall && !fdat) state_nx = S_DATA;
            S_DATA:   if (fall && bit_cnt == 3'd7) state_nx = S_PARITY;
            S_PARITY: if (fall) state_nx = S_STOP;
            S_STOP: begin
                if (fall) begin
                    state_nx = S_IDLE;
                    if ((^{shreg, par_bit}) && fdat) byte_done = 1'b1;
                    else                             frame_err = 1'b1;
                end
            end
            default:  state_nx = S_IDLE;
        endcase
        // A falling edge in the same cycle keeps the frame alive.
        if (state != S_IDLE && !fall && tmo_cnt == TMO_MAX) begin
            state_nx = S_IDLE;
            tmo_hit  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt     <= 3'd0;
            shreg       <= 8'd0;
            par_bit     <= 1'b0;
            tmo_cnt     <= '0;
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
            code        <= 8'd0;
            extended    <= 1'b0;
            key_release <= 1'b0;
            valid       <= 1'b0;
            err         <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;

            if (fall || state == S_IDLE) tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TW'(1);

            if (fall) begin
                case (state)
                    S_IDLE: begin
                        if (!fdat) begin
                            bit_cnt <= 3'd0;
                            shreg   <= 8'd0;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {fdat, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    S_PARITY: par_bit <= fdat;
                    default: ;
                endcase
            end

            if (byte_done) begin
                if (shreg == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else begin
                    code        <= shreg;
                    extended    <= ext_pend;
                    key_release <= brk_pend;
                    valid       <= 1'b1;
                    ext_pend    <= 1'b0;
                    brk_pend    <= 1'b0;
                end
            end

            if (frame_err || tmo_hit) begin
                err      <= 1'b1;
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end
    end

endmodule
